sha256_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one sha256 block core among NUM_REQ requesters (PBKDF2 lanes, HMAC inner/outer units).
- Each requester streams a pre-padded multi-block message as 512-bit chunks.
- The arbiter locks the core to one requester for the whole message, chains the chunks (new_hash on the first only), and returns the final 256-bit digest to that requester.
- It sits between the requester lanes and the single sha256 instance.

---
 rtl/sha256_rr_arbiter.sv | 123 ++++++++++++
 tb/tb_sha256_rr_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_rr_arbiter.sv
// Round-robin arbiter that locks one shared sha256 block core to a single requester
// for a whole multi-chunk message, then returns the final digest to that requester.
module sha256_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDW     = $clog2(NUM_REQ)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [NUM_REQ-1:0]     req_last_i,
  input  logic [NUM_REQ*512-1:0] req_block_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic [NUM_REQ-1:0]     rsp_valid_o,
  output logic [255:0]           rsp_digest_o,
  input  logic [NUM_REQ-1:0]     rsp_ready_i,
  output logic                   core_new_hash_o,
  output logic                   core_in_valid_o,
  output logic [511:0]           core_in_o,
  input  logic                   core_in_ready_i,
  input  logic                   core_out_valid_i,
  input  logic [255:0]           core_out_i,
  output logic                   core_out_ready_o,
  output logic                   busy_o,
  output logic [IDW-1:0]         grant_id_o,
  output logic [31:0]            msg_count_o
);

  // state | meaning
  // IDLE  | no lock held; pick next requester after rr_ptr
  // LOAD  | offer owner's current chunk to the core
  // WAIT  | chunk in flight; acknowledge core output on arrival
  // RESP  | present final digest to owner until consumed
  typedef enum logic [1:0] {IDLE, LOAD, WAIT, RESP} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] owner, rr_ptr, win_id;
  logic           win_found;
  logic           first_r, last_r;
  logic [255:0]   digest_r;
  logic [31:0]    msg_count;
  logic           owner_valid, xfer;

  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      int idx;
      idx = (int'(rr_ptr) + i) % NUM_REQ;
      if (!win_found && req_valid_i[idx]) begin
        win_found = 1'b1;
        win_id    = IDW'(idx);
      end
    end
  end

  assign owner_valid = req_valid_i[owner];
  assign xfer        = (state == LOAD) && owner_valid && core_in_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    req_ready_o      = '0;
    rsp_valid_o      = '0;
    core_new_hash_o  = 1'b0;
    core_in_valid_o  = 1'b0;
    core_in_o        = '0;
    core_out_ready_o = 1'b0;
    case (state)
      IDLE: if (win_found) state_nx = LOAD;
      LOAD: begin
        core_in_valid_o    = owner_valid;
        core_in_o          = req_block_i[32'(owner)*512 +: 512];
        core_new_hash_o    = first_r & owner_valid;
        req_ready_o[owner] = core_in_ready_i;
        if (xfer) state_nx = WAIT;
      end
      WAIT: begin
        core_out_ready_o = core_out_valid_i;
        if (core_out_valid_i) state_nx = last_r ? RESP : LOAD;
      end
      RESP: begin
        rsp_valid_o[owner] = 1'b1;
        if (rsp_ready_i[owner]) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      owner     <= '0;
      rr_ptr    <= IDW'(NUM_REQ - 1);
      first_r   <= 1'b1;
      last_r    <= 1'b0;
      digest_r  <= '0;
      msg_count <= '0;
    end else begin
      if (state == IDLE && win_found) begin
        owner   <= win_id;
        rr_ptr  <= win_id;
        first_r <= 1'b1;
      end
      if (xfer) begin
        last_r  <= req_last_i[owner];
        first_r <= 1'b0;
      end
      if (state == WAIT && core_out_valid_i) begin
        digest_r <= core_out_i;
        if (last_r) msg_count <= msg_count + 32'd1;
      end
    end
  end

  assign rsp_digest_o = digest_r;
  assign busy_o       = (state != IDLE);
  assign grant_id_o   = owner;
  assign msg_count_o  = msg_count;

endmodule

// File: tb/tb_sha256_rr_arbiter.sv
// Directed bench for sha256_rr_arbiter; the bench plays the sha256 core and all requesters.
module tb_sha256_rr_arbiter;
  localparam int NUM_REQ = 4;
  localparam int IDW     = 2;

  logic                   clk_i = 1'b0;
  logic                   rst_ni;
  logic [NUM_REQ-1:0]     req_valid, req_last, req_ready, rsp_valid, rsp_ready;
  logic [NUM_REQ*512-1:0] req_block;
  logic [255:0]           rsp_digest, core_out;
  logic                   core_new_hash, core_in_valid, core_in_ready;
  logic                   core_out_valid, core_out_ready, busy;
  logic [511:0]           core_in;
  logic [IDW-1:0]         grant_id;
  logic [31:0]            msg_count;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] TWO_B0  = {448'h6162636462636465636465666465666765666768666768696768696a68696a6b696a6b6c6a6b6c6d6b6c6d6e6c6d6e6f6d6e6f706e6f7071, 64'h8000000000000000};
  localparam logic [511:0] TWO_B1  = {448'h0, 64'h1c0};
  localparam logic [255:0] D_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] D_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  sha256_rr_arbiter #(.NUM_REQ(NUM_REQ)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_valid_i(req_valid), .req_last_i(req_last), .req_block_i(req_block),
    .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_digest_o(rsp_digest),
    .rsp_ready_i(rsp_ready), .core_new_hash_o(core_new_hash), .core_in_valid_o(core_in_valid),
    .core_in_o(core_in), .core_in_ready_i(core_in_ready), .core_out_valid_i(core_out_valid),
    .core_out_i(core_out), .core_out_ready_o(core_out_ready), .busy_o(busy),
    .grant_id_o(grant_id), .msg_count_o(msg_count)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] fill(input int id, input int k);
    logic [31:0] w;
    w = 32'hC0DE0000 + 32'(id * 16 + k);
    return {16{w}};
  endfunction

  // Caller must be at a falling edge with the requester already granted (state LOAD).
  task automatic run_msg(input int id, input int nblk, input logic [511:0] b0,
                         input logic [511:0] b1, input logic [255:0] dig,
                         input logic [31:0] exp_cnt, input int stall, input int hold);
    logic [511:0]       blk;
    logic [NUM_REQ-1:0] own;
    own     = '0;
    own[id] = 1'b1;
    for (int k = 0; k < nblk; k++) begin
      blk = (k == 0) ? b0 : b1;
      if (k > 0) begin
        for (int s = 0; s < stall; s++) begin
          #1;
          chk("stall_in_valid", core_in_valid, 0);
          chk("stall_grant", grant_id, id);
          chk("stall_req_ready", req_ready, 0);
          chk("stall_busy", busy, 1);
          @(negedge clk_i);
        end
      end
      req_valid[id] = 1'b1;
      req_last[id]  = (k == nblk - 1);
      req_block[id*512 +: 512] = blk;
      core_in_ready = 1'b0;
      #1;
      chk("load_grant", grant_id, id);
      chk("load_busy", busy, 1);
      chk("load_in_valid", core_in_valid, 1);
      chk("load_ready_held", req_ready, 0);
      @(negedge clk_i);
      core_in_ready = 1'b1;
      #1;
      chk("load_new_hash", core_new_hash, (k == 0));
      chk("load_core_in", core_in, blk);
      chk("load_req_ready", req_ready, own);
      @(negedge clk_i);
      req_valid[id] = 1'b0;
      req_last[id]  = 1'b0;
      core_in_ready = 1'b0;
      #1;
      chk("wait_out_ready_low", core_out_ready, 0);
      chk("wait_req_ready", req_ready, 0);
      chk("wait_in_valid", core_in_valid, 0);
      @(negedge clk_i);
      core_out_valid = 1'b1;
      core_out = (k == nblk - 1) ? dig : ~dig;
      #1;
      chk("wait_out_ready", core_out_ready, 1);
      @(negedge clk_i);
      core_out_valid = 1'b0;
    end
    for (int h = 0; h < hold; h++) begin
      #1;
      chk("hold_rsp_valid", rsp_valid, own);
      chk("hold_digest", rsp_digest, dig);
      chk("hold_busy", busy, 1);
      chk("hold_grant", grant_id, id);
      chk("hold_req_ready", req_ready, 0);
      @(negedge clk_i);
    end
    rsp_ready[id] = 1'b1;
    #1;
    chk("resp_valid", rsp_valid, own);
    chk("resp_digest", rsp_digest, dig);
    chk("resp_count", msg_count, exp_cnt);
    @(negedge clk_i);
    rsp_ready[id] = 1'b0;
    #1;
    chk("done_busy", busy, 0);
    chk("done_rsp_valid", rsp_valid, 0);
    chk("done_digest_hold", rsp_digest, dig);
  endtask

  initial begin
    rst_ni = 1'b0;
    req_valid = '0; req_last = '0; req_block = '0; rsp_ready = '0;
    core_in_ready = 1'b0; core_out_valid = 1'b0; core_out = '0;
    @(negedge clk_i);
    @(negedge clk_i);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_count", msg_count, 0);
    chk("rst_digest", rsp_digest, 0);
    chk("rst_handshakes", {req_ready, rsp_valid, core_in_valid, core_new_hash, core_out_ready}, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Single-block "abc" from requester 0
    @(negedge clk_i);
    req_valid[0] = 1'b1;
    req_block[0 +: 512] = ABC_BLK;
    #1;
    chk("idle_no_in_valid", core_in_valid, 0);
    chk("idle_no_ready", req_ready, 0);
    @(negedge clk_i);
    run_msg(0, 1, ABC_BLK, '0, D_ABC, 1, 0, 0);

    // Two-block message from requester 2
    @(negedge clk_i);
    req_valid[2] = 1'b1;
    @(negedge clk_i);
    run_msg(2, 2, TWO_B0, TWO_B1, D_TWO, 2, 0, 0);

    // Reset while waiting for the core
    @(negedge clk_i);
    req_valid[1] = 1'b1;
    @(negedge clk_i);
    core_in_ready = 1'b1;
    #1;
    chk("rstw_grant", grant_id, 1);
    @(negedge clk_i);
    req_valid[1] = 1'b0;
    core_in_ready = 1'b0;
    core_out_valid = 1'b1;
    core_out = D_ABC;
    #1;
    chk("rstw_out_ready", core_out_ready, 1);
    rst_ni = 1'b0;
    #1;
    chk("rstw_out_ready_low", core_out_ready, 0);
    chk("rstw_busy", busy, 0);
    chk("rstw_count", msg_count, 0);
    chk("rstw_grant0", grant_id, 0);
    core_out_valid = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Contention from reset: 0,1,3 -> grant order 0,1,3
    @(negedge clk_i);
    req_valid = 4'b1011;
    @(negedge clk_i);
    run_msg(0, 1, fill(0, 0), '0, 256'h1111, 1, 0, 0);
    @(negedge clk_i);
    run_msg(1, 1, fill(1, 0), '0, 256'h2222, 2, 0, 0);
    @(negedge clk_i);
    run_msg(3, 1, fill(3, 0), '0, 256'h3333, 3, 0, 0);

    // Pointer now at 3: re-raise 0 and 3 -> order 0 then 3
    @(negedge clk_i);
    req_valid[0] = 1'b1;
    req_valid[3] = 1'b1;
    @(negedge clk_i);
    run_msg(0, 1, fill(0, 1), '0, 256'h4444, 4, 0, 0);
    @(negedge clk_i);
    run_msg(3, 1, fill(3, 1), '0, 256'h5555, 5, 0, 0);

    // Owner stalls 5 cycles between chunks while requester 1 waits
    @(negedge clk_i);
    req_valid[0] = 1'b1;
    req_valid[1] = 1'b1;
    @(negedge clk_i);
    run_msg(0, 2, fill(0, 2), fill(0, 3), 256'h6666, 6, 5, 0);

    // Response backpressure for 10 cycles while requester 2 waits
    @(negedge clk_i);
    req_valid[2] = 1'b1;
    @(negedge clk_i);
    run_msg(1, 1, fill(1, 1), '0, 256'h7777, 7, 0, 10);
    @(negedge clk_i);
    run_msg(2, 1, fill(2, 0), '0, 256'h8888, 8, 0, 0);

    @(negedge clk_i);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
